div_arbiter: RTL and testbench

- Shares one iterative 32-bit signed divider between NUM_REQ requesters, e.g. the control core and the hash-scheduler nonce/step logic.
- Selects requesters round-robin, latches their operands, issues the divider start pulse and waits for divider ready.
- Returns quotient and exception to the owning requester with a one-cycle valid.
- Short-circuits divide-by-zero and guards against a hung divider with a timeout.

---
 rtl/div_arbiter_pkg.sv | 15 +
 rtl/div_arbiter_if.sv | 36 +++
 rtl/rr_pick.sv | 31 +++
 rtl/div_arbiter.sv | 163 ++++++++++++++++
 tb/tb_div_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_arbiter_pkg.sv
// Shared types and defaults for the divider arbiter and its round-robin selector.
package div_arb_pkg;

  localparam int unsigned DIV_W           = 32;
  localparam int unsigned TIMEOUT_DEF     = 40;
  localparam int unsigned READY_GUARD_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side and divider-side signals of the shared divider arbiter.
interface div_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  import div_arb_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [DIV_W*NUM_REQ-1:0] req_dividend;
  logic [DIV_W*NUM_REQ-1:0] req_divisor;
  logic [NUM_REQ-1:0]       req_ack;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [DIV_W-1:0]         resp_result;
  logic                     resp_exception;
  logic                     resp_timeout;

  logic [DIV_W-1:0]         div_dividend;
  logic [DIV_W-1:0]         div_divisor;
  logic                     div_start;
  logic                     div_ready;
  logic [DIV_W-1:0]         div_result;
  logic                     div_exception;

  // master: the arbiter; slave: the requesters plus the divider
  modport master (
    input  req, req_dividend, req_divisor, div_ready, div_result, div_exception,
    output req_ack, resp_valid, resp_result, resp_exception, resp_timeout,
           div_dividend, div_divisor, div_start
  );

  modport slave (
    output req, req_dividend, req_divisor, div_ready, div_result, div_exception,
    input  req_ack, resp_valid, resp_result, resp_exception, resp_timeout,
           div_dividend, div_divisor, div_start
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first active request at or after ptr, wrapping at N.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_req
);

  always_comb begin
    int unsigned c;
    logic        found;
    grant   = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    c       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative signed divider among NUM_REQ requesters, round-robin,
// with divide-by-zero short-circuit, stale-ready guard and hang timeout.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned READY_GUARD = READY_GUARD_DEF
) (
  input  logic          clk,
  input  logic          reset,
  div_arbiter_if.master bus,
  output logic          busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e             state, state_n;
  logic [IW-1:0]      rr_ptr, rr_n, owner, owner_n;
  logic [DIV_W-1:0]   dvd_q, dvd_n, dvs_q, dvs_n;
  logic [CW-1:0]      wait_cnt, cnt_n;
  logic [DIV_W-1:0]   res_q, res_n;
  logic               exc_q, exc_n, tmo_q, tmo_n;
  logic [NUM_REQ-1:0] ack_q, ack_n, valid_q, valid_n;
  logic [DIV_W-1:0]   rres_q, rres_n;
  logic               rexc_q, rexc_n, rtmo_q, rtmo_n;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      gidx;
  logic               any_req;
  logic [DIV_W-1:0]   sel_dvd, sel_dvs;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (gidx),
    .any_req (any_req)
  );

  always_comb begin
    sel_dvd = '0;
    sel_dvs = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_dvd = bus.req_dividend[i*DIV_W +: DIV_W];
        sel_dvs = bus.req_divisor[i*DIV_W +: DIV_W];
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    owner_n = owner;
    dvd_n   = dvd_q;
    dvs_n   = dvs_q;
    cnt_n   = wait_cnt;
    res_n   = res_q;
    exc_n   = exc_q;
    tmo_n   = tmo_q;
    ack_n   = '0;
    valid_n = '0;
    rres_n  = '0;
    rexc_n  = 1'b0;
    rtmo_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          ack_n   = grant;
          owner_n = gidx;
          dvd_n   = sel_dvd;
          dvs_n   = sel_dvs;
          if (sel_dvs == '0) begin
            res_n   = '0;
            exc_n   = 1'b1;
            tmo_n   = 1'b0;
            state_n = RESP;
          end else begin
            state_n = START;
          end
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n = wait_cnt + CW'(1);
        // a qualified ready takes priority over a simultaneous timeout
        if (bus.div_ready && (wait_cnt >= CW'(READY_GUARD))) begin
          res_n   = bus.div_result;
          exc_n   = bus.div_exception;
          tmo_n   = 1'b0;
          state_n = RESP;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          res_n   = '0;
          exc_n   = 1'b1;
          tmo_n   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        valid_n[owner] = 1'b1;
        rres_n  = res_q;
        rexc_n  = exc_q;
        rtmo_n  = tmo_q;
        rr_n    = (32'(owner) == NUM_REQ - 1) ? '0 : owner + IW'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      wait_cnt <= '0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      tmo_q    <= 1'b0;
      ack_q    <= '0;
      valid_q  <= '0;
      rres_q   <= '0;
      rexc_q   <= 1'b0;
      rtmo_q   <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      owner    <= owner_n;
      dvd_q    <= dvd_n;
      dvs_q    <= dvs_n;
      wait_cnt <= cnt_n;
      res_q    <= res_n;
      exc_q    <= exc_n;
      tmo_q    <= tmo_n;
      ack_q    <= ack_n;
      valid_q  <= valid_n;
      rres_q   <= rres_n;
      rexc_q   <= rexc_n;
      rtmo_q   <= rtmo_n;
    end
  end

  assign bus.req_ack        = ack_q;
  assign bus.resp_valid     = valid_q;
  assign bus.resp_result    = rres_q;
  assign bus.resp_exception = rexc_q;
  assign bus.resp_timeout   = rtmo_q;
  assign bus.div_dividend   = dvd_q;
  assign bus.div_divisor    = dvs_q;
  assign bus.div_start      = (state == START);
  assign busy               = (state != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a stub divider of programmable latency.
module tb_div_arbiter;

  localparam int TO = 40;
  localparam int RG = 2;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  int   mode = 0;   // 0 normal divider, 1 never ready, 2 stale ready in first WAIT cycles
  int   lat = 34;   // cycles from div_start to ready
  int   scnt = 0;

  div_arbiter_if #(.NUM_REQ(2)) bus ();

  div_arbiter #(
    .NUM_REQ     (2),
    .TIMEOUT     (TO),
    .READY_GUARD (RG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'd0;
    return $signed(a) / $signed(b);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      bus.div_ready     <= 1'b0;
      bus.div_result    <= '0;
      bus.div_exception <= 1'b0;
      scnt              <= 0;
    end else if (bus.div_start) begin
      scnt           <= 1;
      bus.div_ready  <= (mode == 2) || (mode == 0 && lat <= 1);
      bus.div_result <= (mode == 2) ? 32'hdead_beef : sdiv(bus.div_dividend, bus.div_divisor);
    end else if (scnt != 0) begin
      scnt <= scnt + 1;
      if (mode == 2 && scnt < 2) begin
        bus.div_ready  <= 1'b1;
        bus.div_result <= 32'hdead_beef;
      end else if (mode != 1 && scnt + 1 >= lat) begin
        bus.div_ready  <= 1'b1;
        bus.div_result <= sdiv(bus.div_dividend, bus.div_divisor);
      end else begin
        bus.div_ready <= 1'b0;
      end
    end
  end

  // Spec-level timing: ready before the guard window ends is seen at the first
  // qualified WAIT cycle; anything later than TO WAIT cycles is a timeout.
  function automatic bit exp_tmo(input logic [31:0] b);
    int d;
    if (b == 32'd0) return 1'b0;
    if (mode == 1) return 1'b1;
    d = (lat > RG) ? lat : RG + 1;
    return d > TO;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int d;
    if (b == 32'd0) return 1;
    if (exp_tmo(b)) return TO + 2;
    d = (lat > RG) ? lat : RG + 1;
    return d + 2;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  task automatic do_ops(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1, input string nm);
    logic [31:0] a[2], b[2];
    logic [31:0] eq;
    logic [1:0]  pend, eack, evalid;
    int          order[$];
    int          ptr_l, own, ack_cyc, starts, budget;
    bit          inflight, etmo, eexc;
    a[0] = a0; b[0] = b0; a[1] = a1; b[1] = b1;
    pend = mask; ptr_l = m_ptr; own = 0; ack_cyc = 0; starts = 0; inflight = 0;
    while (pend != 2'b00) begin
      for (int k = 0; k < 2; k++) begin
        int c;
        c = (ptr_l + k) % 2;
        if (pend[c]) begin
          order.push_back(c);
          pend[c] = 1'b0;
          ptr_l = (c + 1) % 2;
          break;
        end
      end
    end
    m_ptr = ptr_l;
    @(negedge clk);
    bus.req = mask;
    bus.req_dividend = {a1, a0};
    bus.req_divisor  = {b1, b0};
    budget = 60 * order.size() + 10;
    while (order.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (bus.req_ack != 2'b00) begin
        eack = '0; eack[order[0]] = 1'b1;
        checks++;
        if (inflight || bus.req_ack !== eack) begin
          errors++;
          $display("FAIL %s ack got %b want %b (inflight %0d)", nm, bus.req_ack, eack, inflight);
        end
        inflight = 1; own = order[0]; ack_cyc = cyc; starts = 0;
        bus.req[own] = 1'b0;
      end
      if (bus.div_start) starts++;
      if (bus.resp_valid != 2'b00) begin
        evalid = '0; evalid[own] = 1'b1;
        etmo = exp_tmo(b[own]);
        eexc = etmo || (b[own] == 32'd0);
        eq   = eexc ? 32'd0 : sdiv(a[own], b[own]);
        checks++;
        if (!inflight || bus.resp_valid !== evalid) begin
          errors++;
          $display("FAIL %s resp_valid got %b want %b", nm, bus.resp_valid, evalid);
        end
        checks++;
        if (bus.resp_result !== eq) begin
          errors++;
          $display("FAIL %s result got %0d want %0d", nm, $signed(bus.resp_result), $signed(eq));
        end
        checks++;
        if (bus.resp_exception !== eexc || bus.resp_timeout !== etmo) begin
          errors++;
          $display("FAIL %s exc/tmo got %b/%b want %b/%b", nm, bus.resp_exception,
                   bus.resp_timeout, eexc, etmo);
        end
        checks++;
        if (cyc - ack_cyc != exp_lat(b[own])) begin
          errors++;
          $display("FAIL %s latency got %0d want %0d", nm, cyc - ack_cyc, exp_lat(b[own]));
        end
        checks++;
        if (starts != ((b[own] == 32'd0) ? 0 : 1)) begin
          errors++;
          $display("FAIL %s div_start pulses got %0d want %0d", nm, starts,
                   (b[own] == 32'd0) ? 0 : 1);
        end
        checks++;
        if (bus.div_dividend !== a[own] || bus.div_divisor !== b[own]) begin
          errors++;
          $display("FAIL %s operands got %h/%h want %h/%h", nm, bus.div_dividend,
                   bus.div_divisor, a[own], b[own]);
        end
        order.pop_front();
        inflight = 0;
      end
    end
    checks++;
    if (order.size() != 0) begin
      errors++;
      $display("FAIL %s hang got %0d outstanding want 0", nm, order.size());
    end
    bus.req = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.req_ack !== 2'b00 || bus.resp_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset ack/valid got %b/%b want 00/00", bus.req_ack, bus.resp_valid);
    end
    checks++;
    if (bus.resp_result !== 32'd0 || bus.resp_exception !== 1'b0 || bus.resp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset resp got %h/%b/%b want 0/0/0", bus.resp_result,
               bus.resp_exception, bus.resp_timeout);
    end
    checks++;
    if (busy !== 1'b0 || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL reset busy/start got %b/%b want 0/0", busy, bus.div_start);
    end
    checks++;
    if (bus.div_dividend !== 32'd0 || bus.div_divisor !== 32'd0) begin
      errors++;
      $display("FAIL reset operands got %h/%h want 0/0", bus.div_dividend, bus.div_divisor);
    end
  endtask

  task automatic test_single();
    mode = 0; lat = 34;
    do_ops(2'b01, 32'd100, 32'd7, 32'd0, 32'd0, "single");
  endtask

  task automatic test_signed();
    mode = 0; lat = 34;
    do_ops(2'b01, -32'sd100, 32'sd7, 32'd0, 32'd0, "neg_pos");
    do_ops(2'b10, 32'd0, 32'd0, 32'sd100, -32'sd7, "pos_neg");
    do_ops(2'b01, -32'sd100, -32'sd7, 32'd0, 32'd0, "neg_neg");
  endtask

  task automatic test_simultaneous();
    mode = 0; lat = 34;
    do_reset();
    do_ops(2'b11, 32'd50, 32'd5, 32'd81, 32'd9, "both_from_reset");
    do_ops(2'b01, 32'd60, 32'd6, 32'd0, 32'd0, "advance_ptr");
    do_ops(2'b11, 32'd50, 32'd5, 32'd81, 32'd9, "both_ptr1");
  endtask

  task automatic test_zero_div();
    mode = 0; lat = 34;
    do_ops(2'b10, 32'd0, 32'd0, 32'd1234, 32'd0, "zero_div");
  endtask

  task automatic test_timeout();
    mode = 1;
    do_ops(2'b01, 32'd100, 32'd7, 32'd0, 32'd0, "timeout");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle busy got %b want 0", busy);
    end
    mode = 0;
  endtask

  task automatic test_ready_boundary();
    mode = 0;
    lat = TO;
    do_ops(2'b10, 32'd0, 32'd0, 32'd999, 32'd3, "ready_at_limit");
    lat = TO + 1;
    do_ops(2'b01, 32'd999, 32'd3, 32'd0, 32'd0, "ready_past_limit");
    lat = 1;
    do_ops(2'b10, 32'd0, 32'd0, 32'd77, 32'd7, "early_ready");
    lat = 34;
  endtask

  task automatic test_stale_ready();
    mode = 2; lat = 34;
    do_ops(2'b01, 32'd1000, 32'd8, 32'd0, 32'd0, "stale_ready");
    mode = 0;
  endtask

  task automatic test_reset_mid();
    int budget;
    bit seen;
    mode = 0; lat = 34;
    @(negedge clk);
    bus.req = 2'b01;
    bus.req_dividend = {32'd0, 32'd100};
    bus.req_divisor  = {32'd0, 32'd7};
    budget = 20;
    while (bus.req_ack == 2'b00 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    bus.req = '0;
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL reset_mid ack got none want 01");
    end
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    checks++;
    if (busy !== 1'b0 || bus.resp_valid !== 2'b00 || bus.req_ack !== 2'b00 || bus.div_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ctl got busy %b valid %b ack %b start %b want 0", busy,
               bus.resp_valid, bus.req_ack, bus.div_start);
    end
    checks++;
    if (bus.div_dividend !== 32'd0 || bus.div_divisor !== 32'd0 || bus.resp_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid data got %h/%h/%h want 0", bus.div_dividend, bus.div_divisor,
               bus.resp_result);
    end
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00 || busy) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid stray activity got 1 want 0");
    end
  endtask

  task automatic test_random();
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  mask;
    mode = 0;
    for (int n = 0; n < 16; n++) begin
      mask = 2'($urandom_range(1, 3));
      lat  = $urandom_range(1, 45);
      a0 = $urandom; a1 = $urandom;
      b0 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300));
      b1 = $urandom_range(0, 1) ? -32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 4) == 0) b0 = 32'd0;
      if ($urandom_range(0, 4) == 0) b1 = 32'd0;
      if (a0 == 32'h8000_0000 && b0 == 32'hffff_ffff) b0 = 32'd1;
      if (a1 == 32'h8000_0000 && b1 == 32'hffff_ffff) b1 = 32'd1;
      do_ops(mask, a0, b0, a1, b1, "random");
    end
    lat = 34;
  endtask

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    test_reset();
    test_single();
    test_signed();
    test_simultaneous();
    test_zero_div();
    test_timeout();
    test_ready_boundary();
    test_stale_ready();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
